// File: rtl/ariane_axi_pkg.sv
// ariane_axi: AXI channel/struct types for the CVA6 fetch arbiter; output side carries one extra ID bit.
// Rev 1.0
`default_nettype none
package ariane_axi;
  localparam int unsigned IdWidth    = 4;
  localparam int unsigned IdWidthOut = IdWidth + 1;
  localparam int unsigned AddrWidth  = 64;
  localparam int unsigned DataWidth  = 64;
  localparam int unsigned StrbWidth  = DataWidth / 8;

  typedef enum logic {
    ARB_SRC_DCACHE = 1'b0,
    ARB_SRC_ICACHE = 1'b1
  } arb_src_e;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [3:0]           cache;
    logic [2:0]           prot;
  } ax_chan_t;

  typedef struct packed {
    logic [IdWidthOut-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } ax_chan_out_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidthOut-1:0] id;
    logic [1:0]            resp;
  } b_chan_out_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    logic [IdWidthOut-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_out_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  typedef struct packed {
    ax_chan_out_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    ax_chan_out_t ar;
    logic         ar_valid;
    logic         r_ready;
  } req_out_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    b_chan_out_t b;
    logic        r_valid;
    r_chan_out_t r;
  } resp_out_t;

  function automatic arb_src_e other_src(input arb_src_e s);
    return (s == ARB_SRC_ICACHE) ? ARB_SRC_DCACHE : ARB_SRC_ICACHE;
  endfunction
endpackage
`default_nettype wire

// File: rtl/cva6_axi_outst_cnt.sv
// cva6_axi_outst_cnt: in-flight AR burst counter for one source; full blocks new ARs.
// Rev 1.0
`default_nettype none
module cva6_axi_outst_cnt #(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (inc_i && !dec_i) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (dec_i && !inc_i) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign full_o  = (r_cnt == CntMax);
  assign empty_o = (r_cnt == '0);

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dec_i && !inc_i) |-> !empty_o);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (inc_i && !dec_i) |-> !full_o);
`endif
endmodule
`default_nettype wire

// File: rtl/cva6_axi_fetch_arbiter.sv
// cva6_axi_fetch_arbiter: merges I$ refill reads and D$ AXI onto one master, ID MSB = source.
// Define ICACHE_ARB_PRIO_EN for fixed I$ priority on AR instead of round robin. Rev 1.0
`default_nettype none
module cva6_axi_fetch_arbiter
  import ariane_axi::*;
#(
  parameter int unsigned AxiIdWidth     = ariane_axi::IdWidth,
  parameter int unsigned MaxOutstanding = 4,
  parameter type axi_req_t     = ariane_axi::req_t,
  parameter type axi_rsp_t     = ariane_axi::resp_t,
  parameter type axi_out_req_t = ariane_axi::req_out_t,
  parameter type axi_out_rsp_t = ariane_axi::resp_out_t
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  axi_req_t     icache_req_i,
  output axi_rsp_t     icache_resp_o,
  input  axi_req_t     dcache_req_i,
  output axi_rsp_t     dcache_resp_o,
  output axi_out_req_t axi_req_o,
  input  axi_out_rsp_t axi_resp_i,
  output logic         idle_o
);
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_HOLD = 1'b1;

  logic [0:0] lock_q, lock_d;
  arb_src_e   sel_q, sel_d, rr_q, rr_d;

  logic     ic_full, dc_full, ic_empty, dc_empty;
  logic     ic_elig, dc_elig;
  arb_src_e win_src;
  logic     win_valid;
  logic     ar_hs, r_hs, r_to_ic;
  logic     ic_inc, ic_dec, dc_inc, dc_dec;
  logic     unused_inputs;

  assign ic_elig = icache_req_i.ar_valid & ~ic_full;
  assign dc_elig = dcache_req_i.ar_valid & ~dc_full;

  // In HOLD the latched source stays granted: its counter cannot have grown, so it is still eligible.
  always_comb begin
    win_src   = rr_q;
    win_valid = 1'b0;
    if (lock_q == ARB_HOLD) begin
      win_src   = sel_q;
      win_valid = (sel_q == ARB_SRC_ICACHE) ? icache_req_i.ar_valid : dcache_req_i.ar_valid;
    end else if (ic_elig && dc_elig) begin
`ifdef ICACHE_ARB_PRIO_EN
      win_src = ARB_SRC_ICACHE;
`else
      win_src = rr_q;
`endif
      win_valid = 1'b1;
    end else if (ic_elig) begin
      win_src   = ARB_SRC_ICACHE;
      win_valid = 1'b1;
    end else if (dc_elig) begin
      win_src   = ARB_SRC_DCACHE;
      win_valid = 1'b1;
    end
  end

  assign ar_hs   = win_valid & axi_resp_i.ar_ready;
  assign r_to_ic = axi_resp_i.r.id[AxiIdWidth];
  assign r_hs    = axi_resp_i.r_valid & axi_req_o.r_ready;
  assign ic_inc  = ar_hs & (win_src == ARB_SRC_ICACHE);
  assign dc_inc  = ar_hs & (win_src == ARB_SRC_DCACHE);
  assign ic_dec  = r_hs & axi_resp_i.r.last & r_to_ic;
  assign dc_dec  = r_hs & axi_resp_i.r.last & ~r_to_ic;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= ARB_IDLE;
      sel_q  <= ARB_SRC_ICACHE;
      rr_q   <= ARB_SRC_ICACHE;
    end else begin
      lock_q <= lock_d;
      sel_q  <= sel_d;
      rr_q   <= rr_d;
    end
  end

  always_comb begin
    lock_d = lock_q;
    sel_d  = sel_q;
    rr_d   = rr_q;
    case (lock_q)
      ARB_IDLE: begin
        if (win_valid && !axi_resp_i.ar_ready) begin
          lock_d = ARB_HOLD;
          sel_d  = win_src;
        end
      end
      ARB_HOLD: begin
        if (ar_hs) lock_d = ARB_IDLE;
      end
      default: lock_d = ARB_IDLE;
    endcase
    if (ar_hs) rr_d = other_src(win_src);
  end

  always_comb begin
    axi_req_o     = '0;
    icache_resp_o = '0;
    dcache_resp_o = '0;

    if (win_src == ARB_SRC_ICACHE) begin
      axi_req_o.ar.id    = {1'b1, icache_req_i.ar.id};
      axi_req_o.ar.addr  = icache_req_i.ar.addr;
      axi_req_o.ar.len   = icache_req_i.ar.len;
      axi_req_o.ar.size  = icache_req_i.ar.size;
      axi_req_o.ar.burst = icache_req_i.ar.burst;
      axi_req_o.ar.cache = icache_req_i.ar.cache;
      axi_req_o.ar.prot  = icache_req_i.ar.prot;
    end else begin
      axi_req_o.ar.id    = {1'b0, dcache_req_i.ar.id};
      axi_req_o.ar.addr  = dcache_req_i.ar.addr;
      axi_req_o.ar.len   = dcache_req_i.ar.len;
      axi_req_o.ar.size  = dcache_req_i.ar.size;
      axi_req_o.ar.burst = dcache_req_i.ar.burst;
      axi_req_o.ar.cache = dcache_req_i.ar.cache;
      axi_req_o.ar.prot  = dcache_req_i.ar.prot;
    end
    axi_req_o.ar_valid     = win_valid;
    icache_resp_o.ar_ready = axi_resp_i.ar_ready & win_valid & (win_src == ARB_SRC_ICACHE);
    dcache_resp_o.ar_ready = axi_resp_i.ar_ready & win_valid & (win_src == ARB_SRC_DCACHE);

    axi_req_o.aw.id        = {1'b0, dcache_req_i.aw.id};
    axi_req_o.aw.addr      = dcache_req_i.aw.addr;
    axi_req_o.aw.len       = dcache_req_i.aw.len;
    axi_req_o.aw.size      = dcache_req_i.aw.size;
    axi_req_o.aw.burst     = dcache_req_i.aw.burst;
    axi_req_o.aw.cache     = dcache_req_i.aw.cache;
    axi_req_o.aw.prot      = dcache_req_i.aw.prot;
    axi_req_o.aw_valid     = dcache_req_i.aw_valid;
    axi_req_o.w            = dcache_req_i.w;
    axi_req_o.w_valid      = dcache_req_i.w_valid;
    axi_req_o.b_ready      = dcache_req_i.b_ready;
    dcache_resp_o.aw_ready = axi_resp_i.aw_ready;
    dcache_resp_o.w_ready  = axi_resp_i.w_ready;
    dcache_resp_o.b_valid  = axi_resp_i.b_valid;
    dcache_resp_o.b.id     = axi_resp_i.b.id[AxiIdWidth-1:0];
    dcache_resp_o.b.resp   = axi_resp_i.b.resp;

    icache_resp_o.r.id    = axi_resp_i.r.id[AxiIdWidth-1:0];
    icache_resp_o.r.data  = axi_resp_i.r.data;
    icache_resp_o.r.resp  = axi_resp_i.r.resp;
    icache_resp_o.r.last  = axi_resp_i.r.last;
    dcache_resp_o.r       = icache_resp_o.r;
    icache_resp_o.r_valid = axi_resp_i.r_valid & r_to_ic;
    dcache_resp_o.r_valid = axi_resp_i.r_valid & ~r_to_ic;
    axi_req_o.r_ready     = r_to_ic ? icache_req_i.r_ready : dcache_req_i.r_ready;
  end

  assign idle_o = (lock_q == ARB_IDLE) & ic_empty & dc_empty;

  cva6_axi_outst_cnt #(
    .MaxOutstanding(MaxOutstanding)
  ) u_ic_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ic_inc),
    .dec_i  (ic_dec),
    .full_o (ic_full),
    .empty_o(ic_empty)
  );

  cva6_axi_outst_cnt #(
    .MaxOutstanding(MaxOutstanding)
  ) u_dc_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (dc_inc),
    .dec_i  (dc_dec),
    .full_o (dc_full),
    .empty_o(dc_empty)
  );

  // The I$ port is read-only; its write-side fields exist only because the struct is shared.
  assign unused_inputs = ^{icache_req_i.aw, icache_req_i.aw_valid, icache_req_i.w,
                           icache_req_i.w_valid, icache_req_i.b_ready, axi_resp_i.b.id[AxiIdWidth]};

`ifndef SYNTHESIS
  a_icache_read_only: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(icache_req_i.aw_valid || icache_req_i.w_valid || icache_req_i.b_ready));
  a_b_id_dcache_only: assert property (@(posedge clk_i) disable iff (!rst_ni)
    axi_resp_i.b_valid |-> !axi_resp_i.b.id[AxiIdWidth]);
`endif
endmodule
`default_nettype wire

// File: tb/tb_cva6_axi_fetch_arbiter.sv
// tb_cva6_axi_fetch_arbiter: scoreboard bench for the I$/D$ AXI fetch arbiter (MaxOutstanding=2).
// Rev 1.0
`default_nettype none
module tb_cva6_axi_fetch_arbiter;
  import ariane_axi::*;

  logic      clk;
  logic      rst_n;
  req_t      ic_req, dc_req;
  resp_t     ic_resp, dc_resp;
  req_out_t  axi_req;
  resp_out_t axi_resp;
  logic      idle;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  id;
    logic [63:0] addr;
  } ar_exp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic        last;
  } r_exp_t;

  ar_exp_t    exp_ar[$];
  r_exp_t     exp_ic_r[$];
  r_exp_t     exp_dc_r[$];
  logic [3:0] exp_b[$];
  int         ic_stall = 0;

  cva6_axi_fetch_arbiter #(
    .AxiIdWidth    (4),
    .MaxOutstanding(2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .icache_req_i (ic_req),
    .icache_resp_o(ic_resp),
    .dcache_req_i (dc_req),
    .dcache_resp_o(dc_resp),
    .axi_req_o    (axi_req),
    .axi_resp_i   (axi_resp),
    .idle_o       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  ar_exp_t ea;
  r_exp_t  er;
  logic [3:0] eb;

  always @(negedge clk) begin
    if (rst_n) begin
      check("ic_no_b", {63'd0, ic_resp.b_valid}, 64'd0);
      if (axi_resp.r_valid)
        check("r_exclusive", {63'd0, ic_resp.r_valid & dc_resp.r_valid}, 64'd0);
      if (axi_req.ar_valid && axi_resp.ar_ready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
        else begin
          ea = exp_ar.pop_front();
          check("ar_id", {59'd0, axi_req.ar.id}, {59'd0, ea.id});
          check("ar_addr", axi_req.ar.addr, ea.addr);
        end
      end
      if (ic_resp.r_valid && ic_req.r_ready) begin
        if (exp_ic_r.size() == 0) check("ic_r_unexpected", 64'd1, 64'd0);
        else begin
          er = exp_ic_r.pop_front();
          check("ic_r_id", {60'd0, ic_resp.r.id}, {60'd0, er.id});
          check("ic_r_data", ic_resp.r.data, er.data);
          check("ic_r_last", {63'd0, ic_resp.r.last}, {63'd0, er.last});
        end
      end
      if (dc_resp.r_valid && dc_req.r_ready) begin
        if (exp_dc_r.size() == 0) check("dc_r_unexpected", 64'd1, 64'd0);
        else begin
          er = exp_dc_r.pop_front();
          check("dc_r_id", {60'd0, dc_resp.r.id}, {60'd0, er.id});
          check("dc_r_data", dc_resp.r.data, er.data);
          check("dc_r_last", {63'd0, dc_resp.r.last}, {63'd0, er.last});
        end
      end
      if (dc_resp.b_valid && dc_req.b_ready) begin
        if (exp_b.size() == 0) check("b_unexpected", 64'd1, 64'd0);
        else begin
          eb = exp_b.pop_front();
          check("dc_b_id", {60'd0, dc_resp.b.id}, {60'd0, eb});
        end
      end
    end
  end

  task automatic push_ar(input logic src, input logic [3:0] id, input logic [63:0] addr);
    exp_ar.push_back({src, id, addr});
  endtask

  // Raise the requested AR(s) and wait until each is accepted; reports acceptance cycle per source.
  task automatic issue_ar(input bit do_ic, input bit do_dc,
                          input logic [3:0] ic_id, input logic [3:0] dc_id,
                          input logic [63:0] ic_addr, input logic [63:0] dc_addr,
                          output int ic_c, output int dc_c);
    bit ic_pend, dc_pend, ic_hs, dc_hs;
    ic_pend = do_ic;
    dc_pend = do_dc;
    ic_c = -1;
    dc_c = -1;
    if (do_ic) begin
      ic_req.ar.id = ic_id; ic_req.ar.addr = ic_addr; ic_req.ar.len = 8'd3; ic_req.ar_valid = 1'b1;
    end
    if (do_dc) begin
      dc_req.ar.id = dc_id; dc_req.ar.addr = dc_addr; dc_req.ar.len = 8'd0; dc_req.ar_valid = 1'b1;
    end
    for (int c = 0; c < 30 && (ic_pend || dc_pend); c++) begin
      @(negedge clk);
      ic_hs = ic_pend && ic_resp.ar_ready;
      dc_hs = dc_pend && dc_resp.ar_ready;
      @(posedge clk);
      #1;
      if (ic_hs) begin ic_req.ar_valid = 1'b0; ic_pend = 1'b0; ic_c = c; end
      if (dc_hs) begin dc_req.ar_valid = 1'b0; dc_pend = 1'b0; dc_c = c; end
    end
    check("ar_timeout", {62'd0, ic_pend, dc_pend}, 64'd0);
    if (do_ic) ic_req.ar_valid = 1'b0;
    if (do_dc) dc_req.ar_valid = 1'b0;
  endtask

  task automatic r_beat(input logic src, input logic [3:0] id, input logic [63:0] data,
                        input logic last, input logic exp_ready0);
    bit done;
    done = 1'b0;
    axi_resp.r_valid  = 1'b1;
    axi_resp.r.id     = {src, id};
    axi_resp.r.data   = data;
    axi_resp.r.resp   = 2'b00;
    axi_resp.r.last   = last;
    if (src) exp_ic_r.push_back({id, data, last});
    else     exp_dc_r.push_back({id, data, last});
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 0) check("r_ready_route", {63'd0, axi_req.r_ready}, {63'd0, exp_ready0});
      done = axi_req.r_ready;
      @(posedge clk);
      #1;
      if (ic_stall > 0) begin
        ic_stall--;
        if (ic_stall == 0) ic_req.r_ready = 1'b1;
      end
    end
    check("r_timeout", {63'd0, done}, 64'd1);
    axi_resp.r_valid = 1'b0;
  endtask

  int ic_c, dc_c;

  initial begin
    ic_req   = '0;
    dc_req   = '0;
    axi_resp = '0;
    ic_req.r_ready    = 1'b1;
    dc_req.r_ready    = 1'b1;
    dc_req.b_ready    = 1'b1;
    axi_resp.ar_ready = 1'b1;
    axi_resp.aw_ready = 1'b1;
    axi_resp.w_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", {63'd0, idle}, 64'd1);
    check("rst_ar_valid", {63'd0, axi_req.ar_valid}, 64'd0);
    check("rst_ic_ar_ready", {63'd0, ic_resp.ar_ready}, 64'd0);
    check("rst_ic_r_valid", {63'd0, ic_resp.r_valid}, 64'd0);
    check("rst_dc_b_valid", {63'd0, dc_resp.b_valid}, 64'd0);
    check("rst_r_ready_route", {63'd0, axi_req.r_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single I$ refill, 4 beats
    push_ar(1'b1, 4'd0, 64'h1000);
    issue_ar(1'b1, 1'b0, 4'd0, 4'd0, 64'h1000, 64'h0, ic_c, dc_c);
    check("idle_busy", {63'd0, idle}, 64'd0);
    for (int b = 0; b < 4; b++)
      r_beat(1'b1, 4'd0, 64'hA000 + 64'(b), (b == 3), 1'b1);
    @(negedge clk);
    check("idle_after_refill", {63'd0, idle}, 64'd1);
    @(posedge clk); #1;

    // Lone D$ read so round robin next favours I$
    push_ar(1'b0, 4'd2, 64'h2000);
    issue_ar(1'b0, 1'b1, 4'd0, 4'd2, 64'h0, 64'h2000, ic_c, dc_c);
    r_beat(1'b0, 4'd2, 64'hD200, 1'b1, 1'b1);

    // Simultaneous requests: I$ first, D$ the following cycle
    push_ar(1'b1, 4'd1, 64'h1100);
    push_ar(1'b0, 4'd3, 64'h2100);
    issue_ar(1'b1, 1'b1, 4'd1, 4'd3, 64'h1100, 64'h2100, ic_c, dc_c);
    check("both_ic_first", 64'(ic_c), 64'd0);
    check("both_dc_next", 64'(dc_c), 64'd1);
    r_beat(1'b1, 4'd1, 64'hB100, 1'b1, 1'b1);
    r_beat(1'b0, 4'd3, 64'hD300, 1'b1, 1'b1);

    // ar_ready low: I$ payload held, D$ waits
    axi_resp.ar_ready = 1'b0;
    ic_req.ar.id = 4'd3; ic_req.ar.addr = 64'h3000; ic_req.ar_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, axi_req.ar_valid}, 64'd1);
      check("hold_id", {59'd0, axi_req.ar.id}, 64'h13);
      check("hold_addr", axi_req.ar.addr, 64'h3000);
      check("hold_dc_ready", {63'd0, dc_resp.ar_ready}, 64'd0);
      @(posedge clk); #1;
      if (c == 0) begin
        dc_req.ar.id = 4'd4; dc_req.ar.addr = 64'h4000; dc_req.ar_valid = 1'b1;
      end
    end
    axi_resp.ar_ready = 1'b1;
    push_ar(1'b1, 4'd3, 64'h3000);
    push_ar(1'b0, 4'd4, 64'h4000);
    issue_ar(1'b1, 1'b1, 4'd3, 4'd4, 64'h3000, 64'h4000, ic_c, dc_c);
    check("hold_order", 64'(dc_c - ic_c), 64'd1);
    r_beat(1'b1, 4'd3, 64'hB300, 1'b1, 1'b1);
    r_beat(1'b0, 4'd4, 64'hD400, 1'b1, 1'b1);

    // Outstanding limit of 2 on I$
    push_ar(1'b1, 4'd1, 64'h5100);
    issue_ar(1'b1, 1'b0, 4'd1, 4'd0, 64'h5100, 64'h0, ic_c, dc_c);
    push_ar(1'b1, 4'd2, 64'h5200);
    issue_ar(1'b1, 1'b0, 4'd2, 4'd0, 64'h5200, 64'h0, ic_c, dc_c);
    ic_req.ar.id = 4'd6; ic_req.ar.addr = 64'h6000; ic_req.ar_valid = 1'b1;
    @(negedge clk);
    check("full_ic_ready", {63'd0, ic_resp.ar_ready}, 64'd0);
    check("full_ar_valid", {63'd0, axi_req.ar_valid}, 64'd0);
    @(posedge clk); #1;
    push_ar(1'b0, 4'd7, 64'h7000);
    issue_ar(1'b0, 1'b1, 4'd0, 4'd7, 64'h0, 64'h7000, ic_c, dc_c);
    check("full_dc_accepted", 64'(dc_c), 64'd0);
    @(negedge clk);
    check("full_ic_still_blocked", {63'd0, ic_resp.ar_ready}, 64'd0);
    @(posedge clk); #1;
    r_beat(1'b1, 4'd1, 64'hB510, 1'b1, 1'b1);
    push_ar(1'b1, 4'd6, 64'h6000);
    issue_ar(1'b1, 1'b0, 4'd6, 4'd0, 64'h6000, 64'h0, ic_c, dc_c);
    check("full_third_accepted", {63'd0, ic_c >= 0}, 64'd1);

    // Interleaved R with I$ back-pressure
    ic_req.r_ready = 1'b0;
    ic_stall = 2;
    r_beat(1'b1, 4'd2, 64'hB520, 1'b0, 1'b0);
    r_beat(1'b0, 4'd7, 64'hD700, 1'b1, 1'b1);
    r_beat(1'b1, 4'd2, 64'hB521, 1'b1, 1'b1);
    r_beat(1'b1, 4'd6, 64'hB600, 1'b1, 1'b1);
    @(negedge clk);
    check("idle_after_interleave", {63'd0, idle}, 64'd1);
    @(posedge clk); #1;

    // D$ write
    dc_req.aw.id = 4'd5; dc_req.aw.addr = 64'h8000; dc_req.aw_valid = 1'b1;
    dc_req.w.data = 64'h1234; dc_req.w.strb = 8'hFF; dc_req.w.last = 1'b1; dc_req.w_valid = 1'b1;
    @(negedge clk);
    check("aw_valid", {63'd0, axi_req.aw_valid}, 64'd1);
    check("aw_id", {59'd0, axi_req.aw.id}, 64'h05);
    check("w_data", axi_req.w.data, 64'h1234);
    check("aw_ready", {63'd0, dc_resp.aw_ready}, 64'd1);
    @(posedge clk); #1;
    dc_req.aw_valid = 1'b0; dc_req.w_valid = 1'b0;
    exp_b.push_back(4'd5);
    axi_resp.b_valid = 1'b1; axi_resp.b.id = 5'h05; axi_resp.b.resp = 2'b00;
    @(negedge clk);
    check("b_valid_dc", {63'd0, dc_resp.b_valid}, 64'd1);
    @(posedge clk); #1;
    axi_resp.b_valid = 1'b0;
    @(negedge clk);
    check("idle_after_write", {63'd0, idle}, 64'd1);
    check("sb_ar_empty", 64'(exp_ar.size()), 64'd0);
    check("sb_ic_r_empty", 64'(exp_ic_r.size()), 64'd0);
    check("sb_dc_r_empty", 64'(exp_dc_r.size()), 64'd0);
    check("sb_b_empty", 64'(exp_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
